conv_mac_9: RTL and testbench
=============================

Name: conv_mac_9

Overview:
- Downstream consumer of the layer-9 weight streamer; sits at the start of the layer-9 convolution datapath.
- Pops one coefficient from the weight FIFO and one activation from the activation FIFO per cycle, and accumulates KERN_SIZE products.
- Scales and saturates the sum, then pushes one result per kernel window into the output FIFO.
- All three streams use the codebase's ap_fifo handshake: dout/empty_n/read on inputs, din/full_n/write on the output.

Parameters:
KERN_SIZE, 27, products accumulated per output word (must be >= 2)
COEFF_WIDTH, 8, signed weight width (matches coeff_width)
DATA_WIDTH, 8, signed activation width
OUT_WIDTH, 8, signed output width
SHIFT, 7, arithmetic right shift applied to the accumulator before saturation (0..ACC_WIDTH-1)

Ports:
ap_clk  in  1  clock, rising edge
ap_rst_n  in  1  asynchronous active-low reset
weight_V_dout  in  COEFF_WIDTH  signed coefficient at head of weight FIFO
weight_V_empty_n  in  1  weight FIFO holds data
weight_V_read  out  1  pop weight FIFO this cycle
input_V_dout  in  DATA_WIDTH  signed activation at head of activation FIFO
input_V_empty_n  in  1  activation FIFO holds data
input_V_read  out  1  pop activation FIFO this cycle
output_V_din  out  OUT_WIDTH  signed result
output_V_full_n  in  1  output FIFO has room
output_V_write  out  1  push output_V_din this cycle

Behaviour:
- Local ACC_WIDTH = COEFF_WIDTH + DATA_WIDTH + clog2(KERN_SIZE). Products and the accumulator are signed and full-width, so the accumulator never wraps.
- FSM has 2 states.
  - ACC: fire = weight_V_empty_n & input_V_empty_n. weight_V_read = input_V_read = fire (combinational, same cycle). A pop is never issued on only one stream.
  - On fire: acc <= acc + dout_w*dout_a; cnt <= cnt+1.
  - On fire with cnt == KERN_SIZE-1:
    - sum = acc + product.
    - result <= sat(sum >>> SHIFT).
    - acc <= 0; cnt <= 0; state <= OUT.
  - OUT: output_V_write = output_V_full_n (combinational). Both read strobes are 0.
    - output_V_din = result register, held stable until accepted.
    - When full_n=1 the word is pushed and state <= ACC on the next edge.
- Shift is an arithmetic shift (floor toward -inf). There is no rounding.
- sat clamps to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Throughput is KERN_SIZE+1 cycles per output with both inputs always non-empty and the output never full. There are no bubbles beyond the single OUT cycle.
- Latency from the last pop to the write strobe is 1 cycle, provided full_n=1.
- output_V_din is registered. The read and write strobes are combinational from state and the flags, with no combinational path from any dout to any strobe.
- Reset (ap_rst_n=0, asynchronous):
  - state=ACC, cnt=0, acc=0, result=0.
  - weight_V_read, input_V_read and output_V_write are forced to 0 while reset is asserted. The strobes are gated by ap_rst_n.
  - output_V_din=0.
- Reset mid-window discards the partial sum. The next output uses KERN_SIZE fresh pairs.
- Reset in OUT drops the pending word; no write occurs.
- Empty on either input stalls ACC with acc and cnt held. No partial pop occurs.
- full_n deasserted in OUT stalls indefinitely with din stable. Input FIFOs are not read during the stall.

Test Plan:
- KERN_SIZE=4, SHIFT=0, OUT_WIDTH=16; weights 1,2,3,4, activations 10,20,30,40, streams always valid -> one write of 300, exactly 4 reads per stream, write 1 cycle after the 4th pop, then ACC resumes.
- KERN_SIZE=4, SHIFT=0, OUT_WIDTH=8; weights 127 x4, acts 127 x4 -> output 127 (sum 64516 saturated). Weights -128 x4, acts 127 x4 -> -128.
- KERN_SIZE=4, SHIFT=7, OUT_WIDTH=8; the first case's data -> 2. Activations negated (sum -300) -> -3.
- Backpressure: hold full_n=0 for 5 cycles when OUT is entered -> write=0, din constant, no reads. Raise full_n -> exactly one write, and reads resume next cycle.
- Stream skew: weight FIFO non-empty, activation empty_n toggling 1,0,0,1,... -> reads only on cycles where both are non-empty, strobes identical, result equals the reference sum.
- Reset after 2 of 4 pops, then feed 4 fresh pairs -> single output equals the sum of the fresh pairs only. All strobes are 0 during reset, and din=0 after reset.

Source files
------------

// File: rtl/conv_mac_9.sv
// conv_mac_9 -- layer-9 convolution multiply-accumulate.
//
// Pops one signed weight and one signed activation per cycle, but only when
// both FIFOs hold data. After KERN_SIZE products it arithmetic-shifts the sum
// right by SHIFT, saturates it to OUT_WIDTH and pushes the word to the output
// FIFO. The FIFOs use the ap_fifo handshake.
//
// Ports:
//   ap_clk, ap_rst_n            clock (rising edge), asynchronous active-low reset
//   weight_V_dout/_empty_n      weight FIFO head and its not-empty flag
//   weight_V_read               pop strobe for the weight FIFO
//   input_V_dout/_empty_n       activation FIFO head and its not-empty flag
//   input_V_read                pop strobe for the activation FIFO
//   output_V_din                registered, saturated result
//   output_V_full_n             output FIFO has room
//   output_V_write              push strobe for the output FIFO
module conv_mac_9 #(
    parameter int KERN_SIZE   = 27,
    parameter int COEFF_WIDTH = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT       = 7
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [COEFF_WIDTH-1:0] weight_V_dout,
    input  logic                   weight_V_empty_n,
    output logic                   weight_V_read,
    input  logic [DATA_WIDTH-1:0]  input_V_dout,
    input  logic                   input_V_empty_n,
    output logic                   input_V_read,
    output logic [OUT_WIDTH-1:0]   output_V_din,
    input  logic                   output_V_full_n,
    output logic                   output_V_write
);

    localparam int ACC_WIDTH  = COEFF_WIDTH + DATA_WIDTH + $clog2(KERN_SIZE);
    localparam int PROD_WIDTH = COEFF_WIDTH + DATA_WIDTH;
    localparam int CNT_WIDTH  = $clog2(KERN_SIZE);

    // Saturation bounds held at accumulator width. ~max is the most negative value.
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic signed [OUT_WIDTH-1:0]   result_q, result_d;

    logic signed [PROD_WIDTH-1:0]  w_ext;
    logic signed [PROD_WIDTH-1:0]  a_ext;
    logic signed [PROD_WIDTH-1:0]  prod;
    logic signed [ACC_WIDTH-1:0]   sum;
    logic signed [ACC_WIDTH-1:0]   sum_shifted;
    logic                          fire;
    logic                          last;

    function automatic logic signed [OUT_WIDTH-1:0] sat(
        input logic signed [ACC_WIDTH-1:0] v
    );
        logic signed [ACC_WIDTH-1:0] c;
        if (v > OUT_MAX) begin
            c = OUT_MAX;
        end else if (v < OUT_MIN) begin
            c = OUT_MIN;
        end else begin
            c = v;
        end
        return c[OUT_WIDTH-1:0];
    endfunction

    // Both operands are sign-extended to the full product width before the
    // multiply, so the product is exact.
    assign w_ext       = PROD_WIDTH'($signed(weight_V_dout));
    assign a_ext       = PROD_WIDTH'($signed(input_V_dout));
    assign prod        = w_ext * a_ext;
    assign sum         = acc_q + ACC_WIDTH'(prod);
    assign sum_shifted = sum >>> SHIFT;

    // The strobes depend only on the state, the flags and the reset. No FIFO
    // data path feeds them. A pop always takes both streams together.
    assign fire           = ap_rst_n && (state_q == ST_ACC) && weight_V_empty_n && input_V_empty_n;
    assign weight_V_read  = fire;
    assign input_V_read   = fire;
    assign output_V_write = ap_rst_n && (state_q == ST_OUT) && output_V_full_n;
    assign output_V_din   = result_q;

    assign last = (cnt_q == CNT_WIDTH'(KERN_SIZE - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        if (fire) begin
            if (last) begin
                // Close the window: scale, clamp and hold for the output FIFO.
                result_d = sat(sum_shifted);
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = ST_OUT;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
        if (output_V_write) begin
            state_d = ST_ACC;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q  <= ST_ACC;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_conv_mac_9.sv
// Bench for conv_mac_9: three instances with KERN_SIZE=4 and different
// SHIFT/OUT_WIDTH share one stimulus. A behavioural model predicts the
// strobes and output words on every cycle.
module tb_conv_mac_9;

    localparam int KERN = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  w_dout;
    logic        w_en;
    logic [7:0]  a_dout;
    logic        a_en;
    logic        full_n;
    logic        w_rd [3];
    logic        a_rd [3];
    logic        wrt  [3];
    logic [15:0] din_a;
    logic [7:0]  din_b;
    logic [7:0]  din_c;

    always #5 clk = ~clk;

    conv_mac_9 #(.KERN_SIZE(KERN), .COEFF_WIDTH(8), .DATA_WIDTH(8), .OUT_WIDTH(16), .SHIFT(0)) u_a (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .weight_V_dout(w_dout), .weight_V_empty_n(w_en), .weight_V_read(w_rd[0]),
        .input_V_dout(a_dout), .input_V_empty_n(a_en), .input_V_read(a_rd[0]),
        .output_V_din(din_a), .output_V_full_n(full_n), .output_V_write(wrt[0]));

    conv_mac_9 #(.KERN_SIZE(KERN), .COEFF_WIDTH(8), .DATA_WIDTH(8), .OUT_WIDTH(8), .SHIFT(0)) u_b (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .weight_V_dout(w_dout), .weight_V_empty_n(w_en), .weight_V_read(w_rd[1]),
        .input_V_dout(a_dout), .input_V_empty_n(a_en), .input_V_read(a_rd[1]),
        .output_V_din(din_b), .output_V_full_n(full_n), .output_V_write(wrt[1]));

    conv_mac_9 #(.KERN_SIZE(KERN), .COEFF_WIDTH(8), .DATA_WIDTH(8), .OUT_WIDTH(8), .SHIFT(7)) u_c (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .weight_V_dout(w_dout), .weight_V_empty_n(w_en), .weight_V_read(w_rd[2]),
        .input_V_dout(a_dout), .input_V_empty_n(a_en), .input_V_read(a_rd[2]),
        .output_V_din(din_c), .output_V_full_n(full_n), .output_V_write(wrt[2]));

    int     n_vec = 0;
    int     n_bad = 0;
    int     wq[$];
    int     aq[$];
    int     cyc = 0;
    int     npop_w = 0;
    int     npop_a = 0;
    logic   skew = 1'b0;
    logic   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int     cfg_shift [3] = '{0, 0, 7};
    int     cfg_width [3] = '{16, 8, 8};

    // Model state.
    logic   m_hold = 1'b0;
    int     m_n = 0;
    longint m_sum = 0;
    longint m_res [3] = '{0, 0, 0};
    longint outq [3][$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Floor division by 2^sh, then clamp to a signed ow-bit range.
    function automatic longint expect_of(input longint s, input int sh, input int ow);
        longint d, q, hi, lo;
        d  = longint'(1) << sh;
        q  = (s >= 0) ? s / d : -((-s + d - 1) / d);
        hi = (longint'(1) << (ow - 1)) - 1;
        lo = -(longint'(1) << (ow - 1));
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return q;
    endfunction

    // Per-cycle compare. The inputs are stable here, so this cycle's expected
    // strobes come from them. The model then advances to the next clock edge.
    initial begin
        logic   er, ew;
        longint dv [3];
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_hold = 1'b0;
                m_n    = 0;
                m_sum  = 0;
                for (int k = 0; k < 3; k++) m_res[k] = 0;
            end
            er = rst_n && !m_hold && w_en && a_en;
            ew = rst_n && m_hold && full_n;
            dv[0] = longint'($signed(din_a));
            dv[1] = longint'($signed(din_b));
            dv[2] = longint'($signed(din_c));
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("w_read[%0d]", k), longint'(w_rd[k]), longint'(er));
                chk($sformatf("a_read[%0d]", k), longint'(a_rd[k]), longint'(er));
                chk($sformatf("write[%0d]", k), longint'(wrt[k]), longint'(ew));
                chk($sformatf("din[%0d]", k), dv[k], m_res[k]);
            end
            if (ew) begin
                for (int k = 0; k < 3; k++) outq[k].push_back(m_res[k]);
                m_hold = 1'b0;
            end else if (er) begin
                m_sum += longint'($signed(w_dout)) * longint'($signed(a_dout));
                m_n++;
                if (m_n == KERN) begin
                    for (int k = 0; k < 3; k++) m_res[k] = expect_of(m_sum, cfg_shift[k], cfg_width[k]);
                    m_sum  = 0;
                    m_n    = 0;
                    m_hold = 1'b1;
                end
            end
        end
    end

    task automatic drive();
        w_en   = (wq.size() > 0);
        a_en   = (aq.size() > 0) && (!skew || pat[cyc % 4]);
        w_dout = (wq.size() > 0) ? 8'(wq[0]) : 8'h00;
        a_dout = (aq.size() > 0) ? 8'(aq[0]) : 8'h00;
    endtask

    // One clock: the bench FIFOs react to the strobes of instance 0. The
    // strobes are sampled at negedge and inputs change 1 time unit after posedge.
    task automatic step();
        logic pw, pa;
        @(negedge clk);
        pw = w_rd[0];
        pa = a_rd[0];
        @(posedge clk);
        #1;
        cyc++;
        if (pw && wq.size() > 0) begin void'(wq.pop_front()); npop_w++; end
        if (pa && aq.size() > 0) begin void'(aq.pop_front()); npop_a++; end
        drive();
    endtask

    task automatic load(input int w0, input int w1, input int w2, input int w3,
                        input int a0, input int a1, input int a2, input int a3);
        wq.push_back(w0); wq.push_back(w1); wq.push_back(w2); wq.push_back(w3);
        aq.push_back(a0); aq.push_back(a1); aq.push_back(a2); aq.push_back(a3);
        drive();
    endtask

    task automatic run_outputs(input string name, input int n, input int budget);
        int target, c;
        target = outq[0].size() + n;
        c = 0;
        while (outq[0].size() < target && c < budget) begin
            step();
            c++;
        end
        chk({name, "_out_count"}, longint'(outq[0].size()), longint'(target));
    endtask

    task automatic run_pops(input string name, input int n, input int budget);
        int c;
        c = 0;
        while (npop_w < n && c < budget) begin
            step();
            c++;
        end
        chk({name, "_pops"}, longint'(npop_w), longint'(n));
    endtask

    task automatic chk_last(input string name, input longint e0, input longint e1, input longint e2);
        longint e [3];
        e = '{e0, e1, e2};
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s_lit[%0d]", name, k),
                (outq[k].size() > 0) ? outq[k][$] : -999999, e[k]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int     base;
        longint held;
        rst_n  = 1'b0;
        full_n = 1'b1;
        drive();
        repeat (3) step();
        chk("rst_din_a", longint'(din_a), 0);
        chk("rst_wread", longint'(w_rd[0]), 0);
        rst_n = 1'b1;
        step();

        // Basic sum 300.
        npop_w = 0; npop_a = 0;
        load(1, 2, 3, 4, 10, 20, 30, 40);
        run_outputs("basic", 1, 20);
        chk_last("basic", 300, 127, 2);
        chk("basic_wpops", longint'(npop_w), 4);
        chk("basic_apops", longint'(npop_a), 4);

        // Positive saturation (sum 64516).
        load(127, 127, 127, 127, 127, 127, 127, 127);
        run_outputs("satpos", 1, 20);
        chk_last("satpos", 32767, 127, 127);

        // Negative saturation (sum -65024).
        load(-128, -128, -128, -128, 127, 127, 127, 127);
        run_outputs("satneg", 1, 20);
        chk_last("satneg", -32768, -128, -128);

        // Negative floor shift (sum -300).
        load(1, 2, 3, 4, -10, -20, -30, -40);
        run_outputs("negshift", 1, 20);
        chk_last("negshift", -300, -128, -3);

        // Backpressure: two windows queued, full_n held low for 5 cycles in OUT.
        npop_w = 0; npop_a = 0;
        load(5, 6, 7, 8, 1, 1, 1, 1);
        load(1, 1, 1, 1, 2, 2, 2, 2);
        run_pops("bp", 4, 20);
        full_n = 1'b0;
        base = outq[0].size();
        held = longint'($signed(din_a));
        repeat (5) step();
        chk("bp_din_stable", longint'($signed(din_a)), held);
        chk("bp_no_pops", longint'(npop_w), 4);
        chk("bp_no_write", longint'(outq[0].size()), longint'(base));
        full_n = 1'b1;
        run_outputs("bp1", 1, 10);
        chk_last("bp1", 26, 26, 0);
        run_outputs("bp2", 1, 20);
        chk_last("bp2", 8, 8, 0);

        // Activation stream skew 1,0,0,1.
        skew = 1'b1;
        npop_w = 0; npop_a = 0;
        load(-1, 2, -3, 4, 3, 3, 3, 3);
        run_outputs("skew", 1, 40);
        chk_last("skew", 6, 6, 0);
        chk("skew_pops_eq", longint'(npop_w), longint'(npop_a));
        skew = 1'b0;
        drive();

        // Reset mid-window, then a fresh window.
        npop_w = 0; npop_a = 0;
        load(9, 9, 9, 9, 9, 9, 9, 9);
        run_pops("rstmid", 2, 20);
        rst_n = 1'b0;
        wq.delete(); aq.delete();
        drive();
        repeat (3) step();
        chk("rstmid_din", longint'(din_a), 0);
        chk("rstmid_write", longint'(wrt[0]), 0);
        rst_n = 1'b1;
        step();
        load(2, 2, 2, 2, 3, 3, 3, 3);
        run_outputs("rstmid", 1, 20);
        chk_last("rstmid", 24, 24, 0);

        // Reset while a word is pending in OUT: the word is dropped.
        npop_w = 0;
        load(1, 1, 1, 1, 1, 1, 1, 1);
        run_pops("rstout", 4, 20);
        full_n = 1'b0;
        step();
        base = outq[0].size();
        rst_n = 1'b0;
        drive();
        repeat (2) step();
        full_n = 1'b1;
        rst_n = 1'b1;
        drive();
        repeat (4) step();
        chk("rstout_dropped", longint'(outq[0].size()), longint'(base));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
